// File: rtl/jump_pkg.sv
// jump_pkg: shared states, op kinds, opcodes, branch funct3, ALU ops and exception numbers for the jump unit
package jump_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LINK, S_CMP, S_TARGET, S_DONE} state_t;
  typedef enum logic [1:0] {K_JAL, K_JALR, K_BR, K_ILL} kind_t;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ = 3'd0;
  localparam logic [2:0] F3_BNE = 3'd1;
  localparam logic [2:0] F3_BLT = 3'd4;
  localparam logic [2:0] F3_BGE = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd8;
  localparam int EXC_INSN_MISALIGNED = 0;
  localparam int EXC_ILLEGAL = 2;
endpackage

// File: rtl/execute_jump_seq_if.sv
// execute_jump_seq_if: decode/operand input, shared-ALU and result handshakes of the jump unit
interface execute_jump_seq_if #(parameter int XLEN = 32, parameter int EXC_W = 6);
  logic in_valid, in_ready;
  logic [6:0] decode_opcode;
  logic [2:0] decode_funct3;
  logic [XLEN-1:0] decode_imm, decode_pc, read_rs1_val, read_rs2_val;
  logic [XLEN:0] alu_in_a, alu_in_b;
  logic [4:0] alu_op;
  logic alu_valid;
  logic [XLEN-1:0] alu_result;
  logic alu_lt, alu_ltu, alu_eq;
  logic out_valid, out_ready;
  logic [XLEN-1:0] rd_val_out, pc_out;
  logic rd_write, jump_pc;
  logic [EXC_W-1:0] exception_num_out;
  logic exception_valid_out;
  modport slave (
    input in_valid, decode_opcode, decode_funct3, decode_imm, decode_pc, read_rs1_val, read_rs2_val,
    input alu_result, alu_lt, alu_ltu, alu_eq, out_ready,
    output in_ready, alu_in_a, alu_in_b, alu_op, alu_valid,
    output out_valid, rd_val_out, rd_write, pc_out, jump_pc, exception_num_out, exception_valid_out
  );
  modport master (
    output in_valid, decode_opcode, decode_funct3, decode_imm, decode_pc, read_rs1_val, read_rs2_val,
    output alu_result, alu_lt, alu_ltu, alu_eq, out_ready,
    input in_ready, alu_in_a, alu_in_b, alu_op, alu_valid,
    input out_valid, rd_val_out, rd_write, pc_out, jump_pc, exception_num_out, exception_valid_out
  );
endinterface

// File: rtl/execute_jump_seq_cond.sv
// branch_cond_eval: maps branch funct3 and ALU compare flags to taken / illegal
module branch_cond_eval
  import jump_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       eq_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       taken_o,
  output logic       illegal_o
);
  always_comb begin
    taken_o = funct3_i == F3_BEQ  ? eq_i :
              funct3_i == F3_BNE  ? !eq_i :
              funct3_i == F3_BLT  ? lt_i :
              funct3_i == F3_BGE  ? !lt_i :
              funct3_i == F3_BLTU ? ltu_i :
              funct3_i == F3_BGEU ? !ltu_i : 1'b0;
    illegal_o = funct3_i inside {3'd2, 3'd3};
  end
endmodule

// File: rtl/execute_jump_seq.sv
// execute_jump_seq: multi-cycle JAL/JALR/branch execute unit driving the shared ALU
module execute_jump_seq
  import jump_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN_BYTES = 4,
  parameter int COMPRESSED = 0,
  parameter int EXC_W = 6
) (
  input logic clk,
  input logic reset_n,
  input logic flush,
  execute_jump_seq_if.slave bus
);
  state_t state_q;
  kind_t kind_q, kind_d;
  logic [2:0] funct3_q, f3;
  logic [XLEN-1:0] imm_q, pc_q, rs1_q, rs2_q, link_q, tgt;
  logic out_valid_q, rd_write_q, jump_q, exc_valid_q;
  logic [XLEN-1:0] rd_val_q, pc_out_q;
  logic [EXC_W-1:0] exc_num_q;
  logic taken, br_ill, sgn, alu_on, mis;
  // funct3 is live from decode while idle so branch legality is known at accept
  assign f3 = state_q == S_IDLE ? bus.decode_funct3 : funct3_q;
  branch_cond_eval u_cond (
    .funct3_i(f3), .eq_i(bus.alu_eq), .lt_i(bus.alu_lt), .ltu_i(bus.alu_ltu),
    .taken_o(taken), .illegal_o(br_ill)
  );
  assign kind_d = bus.decode_opcode == OP_JAL ? K_JAL :
                  bus.decode_opcode == OP_JALR && bus.decode_funct3 == 3'd0 ? K_JALR :
                  bus.decode_opcode == OP_BRANCH && !br_ill ? K_BR : K_ILL;
  assign sgn = funct3_q == F3_BLT || funct3_q == F3_BGE;
  // illegal ops walk LINK/TARGET only to keep the common latency, without touching the ALU
  assign alu_on = state_q == S_CMP || ((state_q == S_LINK || state_q == S_TARGET) && kind_q != K_ILL);
  assign tgt = kind_q == K_JALR ? {bus.alu_result[XLEN-1:1], 1'b0} : bus.alu_result;
  assign mis = COMPRESSED != 0 ? tgt[0] : tgt[1];
  assign bus.alu_valid = alu_on;
  assign bus.alu_op = state_q == S_CMP ? ALU_SUB : ALU_ADD;
  assign bus.alu_in_a = !alu_on ? '0 : state_q == S_CMP ? {sgn & rs1_q[XLEN-1], rs1_q} :
                        {1'b0, state_q == S_TARGET && kind_q == K_JALR ? rs1_q : pc_q};
  assign bus.alu_in_b = !alu_on ? '0 : state_q == S_CMP ? {sgn & rs2_q[XLEN-1], rs2_q} :
                        {1'b0, state_q == S_LINK ? XLEN'(ILEN_BYTES) : imm_q};
  assign bus.in_ready = state_q == S_IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.rd_val_out = rd_val_q;
  assign bus.rd_write = rd_write_q;
  assign bus.pc_out = pc_out_q;
  assign bus.jump_pc = jump_q;
  assign bus.exception_num_out = exc_num_q;
  assign bus.exception_valid_out = exc_valid_q;
  // result registers are zero whenever the unit leaves DONE, so each path only sets its own fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      kind_q <= K_JAL;
      funct3_q <= '0;
      imm_q <= '0;
      pc_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      link_q <= '0;
      out_valid_q <= 1'b0;
      rd_val_q <= '0;
      rd_write_q <= 1'b0;
      pc_out_q <= '0;
      jump_q <= 1'b0;
      exc_num_q <= '0;
      exc_valid_q <= 1'b0;
    end else if (flush || (state_q == S_DONE && bus.out_ready)) begin
      state_q <= S_IDLE;
      out_valid_q <= 1'b0;
      rd_val_q <= '0;
      rd_write_q <= 1'b0;
      pc_out_q <= '0;
      jump_q <= 1'b0;
      exc_num_q <= '0;
      exc_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          kind_q <= kind_d;
          funct3_q <= bus.decode_funct3;
          imm_q <= bus.decode_imm;
          pc_q <= bus.decode_pc;
          rs1_q <= bus.read_rs1_val;
          rs2_q <= bus.read_rs2_val;
          state_q <= kind_d == K_BR ? S_CMP : S_LINK;
        end
        S_CMP: state_q <= taken ? S_TARGET : S_LINK;
        S_LINK: if (kind_q == K_BR) begin
          state_q <= S_DONE;
          out_valid_q <= 1'b1;
          pc_out_q <= bus.alu_result;
        end else begin
          link_q <= bus.alu_result;
          state_q <= S_TARGET;
        end
        S_TARGET: begin
          state_q <= S_DONE;
          out_valid_q <= 1'b1;
          if (kind_q == K_ILL) begin
            exc_valid_q <= 1'b1;
            exc_num_q <= EXC_W'(EXC_ILLEGAL);
          end else begin
            pc_out_q <= tgt;
            rd_val_q <= kind_q == K_BR ? '0 : link_q;
            rd_write_q <= kind_q != K_BR && !mis;
            jump_q <= !mis;
            exc_valid_q <= mis;
            exc_num_q <= EXC_W'(EXC_INSN_MISALIGNED);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_jump_seq.sv
// tb_execute_jump_seq: scoreboard bench running COMPRESSED=0 and COMPRESSED=1 units in lockstep
module tb_execute_jump_seq;
  import jump_pkg::*;
  typedef struct packed {
    logic [31:0] rd_val;
    logic        rd_write;
    logic [31:0] pc_out;
    logic        jump;
    logic [5:0]  exc_num;
    logic        exc_valid;
  } res_t;
  typedef struct {
    int   cyc;
    res_t e0;
    res_t e1;
  } exp_t;
  logic clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 1, done = 0;
  logic [6:0] opc = '0;
  logic [2:0] f3 = '0;
  logic [31:0] imm = '0, pc = '0, rs1 = '0, rs2 = '0;
  res_t [1:0] r;
  logic [1:0] ov, ir, av;
  exp_t exp_q[$];
  int cyc = 0, n_pass = 0, n_tot = 0, n_ops = 0, ops_exp = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : inst
    execute_jump_seq_if #(.XLEN(32), .EXC_W(6)) bi ();
    execute_jump_seq #(.XLEN(32), .ILEN_BYTES(4), .COMPRESSED(g), .EXC_W(6)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bi.slave)
    );
    assign bi.in_valid = in_valid;
    assign bi.decode_opcode = opc;
    assign bi.decode_funct3 = f3;
    assign bi.decode_imm = imm;
    assign bi.decode_pc = pc;
    assign bi.read_rs1_val = rs1;
    assign bi.read_rs2_val = rs2;
    assign bi.out_ready = out_ready;
    always_comb begin
      bi.alu_result = bi.alu_op == ALU_SUB ? bi.alu_in_a[31:0] - bi.alu_in_b[31:0]
                                           : bi.alu_in_a[31:0] + bi.alu_in_b[31:0];
      bi.alu_eq = bi.alu_in_a == bi.alu_in_b;
      bi.alu_lt = $signed(bi.alu_in_a) < $signed(bi.alu_in_b);
      bi.alu_ltu = bi.alu_in_a[31:0] < bi.alu_in_b[31:0];
    end
    assign r[g] = {bi.rd_val_out, bi.rd_write, bi.pc_out, bi.jump_pc, bi.exception_num_out, bi.exception_valid_out};
    assign ov[g] = bi.out_valid;
    assign ir[g] = bi.in_ready;
    assign av[g] = bi.alu_valid;
  end
  function automatic res_t model(int c, logic [6:0] o, logic [2:0] f, logic [31:0] i, p, a, b);
    res_t e = '0;
    logic [31:0] t = p + i;
    logic tk = 1'b1, bad = 1'b0, mis;
    case (o)
      OP_JAL: e.rd_val = p + 4;
      OP_JALR: begin t = (a + i) & ~32'd1; bad = f != 3'd0; e.rd_val = p + 4; end
      OP_BRANCH: case (f)
        3'd0: tk = a == b;
        3'd1: tk = a != b;
        3'd4: tk = $signed(a) < $signed(b);
        3'd5: tk = $signed(a) >= $signed(b);
        3'd6: tk = a < b;
        3'd7: tk = a >= b;
        default: bad = 1'b1;
      endcase
      default: bad = 1'b1;
    endcase
    if (bad) begin
      e = '0;
      e.exc_valid = 1'b1;
      e.exc_num = 6'd2;
      return e;
    end
    if (!tk) begin
      e.pc_out = p + 4;
      return e;
    end
    mis = c != 0 ? t[0] : t[1];
    e.pc_out = t;
    e.exc_valid = mis;
    e.jump = !mis;
    e.rd_write = o != OP_BRANCH && !mis;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, got, want);
  endtask
  // monitor/scoreboard: the only process that checks, pushes and pops
  always @(negedge clk) begin
    logic pend, want_ov;
    cyc++;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("reset_outputs", {ov[i], r[i], av[i]}, '0);
        chk("reset_in_ready", ir[i], 1);
      end
      exp_q.delete();
    end else begin
      pend = exp_q.size() != 0;
      want_ov = 1'b0;
      if (pend) want_ov = cyc - exp_q[0].cyc >= 3;
      for (int i = 0; i < 2; i++) begin
        chk("out_valid", ov[i], want_ov);
        chk("in_ready", ir[i], !pend);
        if (!pend) chk("alu_idle", av[i], 0);
      end
      if (want_ov) begin
        chk("result_c0", r[0], exp_q[0].e0);
        chk("result_c1", r[1], exp_q[0].e1);
      end
      if (flush) exp_q.delete();
      else if (want_ov && out_ready) begin
        void'(exp_q.pop_front());
        n_ops++;
      end else if (!pend && in_valid)
        exp_q.push_back('{cyc, model(0, opc, f3, imm, pc, rs1, rs2), model(1, opc, f3, imm, pc, rs1, rs2)});
    end
    if (done) begin
      chk("ops_completed", n_ops, ops_exp);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
    end
  end
  task automatic issue(input logic [6:0] o, input logic [2:0] f, input logic [31:0] i, p, a, b);
    for (int k = 0; k < 20 && !ir[0]; k++) @(posedge clk) #1;
    opc = o; f3 = f; imm = i; pc = p; rs1 = a; rs2 = b;
    in_valid = 1;
    @(posedge clk) #1;
    in_valid = 0;
  endtask
  task automatic go(input logic [6:0] o, input logic [2:0] f, input logic [31:0] i, p, a, b,
                    input int stall, input bit rnd);
    logic hit = 1'b0;
    issue(o, f, i, p, a, b);
    ops_exp++;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (ov[0] && stall > 0) begin
        out_ready = 0;
        stall--;
      end else out_ready = rnd ? $urandom_range(0, 2) != 0 : 1'b1;
      hit = ov[0] && out_ready;
      @(posedge clk) #1;
    end
  endtask
  task automatic abort(input logic [6:0] o, input logic [2:0] f, input logic [31:0] i, p, a, b, input int d);
    issue(o, f, i, p, a, b);
    repeat (d) @(posedge clk) #1;
    flush = 1;
    out_ready = 1;
    @(posedge clk) #1;
    flush = 0;
  endtask
  initial begin
    logic [6:0] o;
    logic [2:0] f;
    logic [31:0] a;
    int sel;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk) #1;
    go(OP_JAL, 0, 32'h20, 32'h100, 0, 0, 0, 0);
    go(OP_JALR, 0, 0, 32'h300, 32'h203, 0, 0, 0);
    go(OP_BRANCH, 6, -32'sd8, 32'h40, 32'hFFFF_FFFF, 1, 0, 0);
    go(OP_BRANCH, 4, -32'sd8, 32'h40, 32'hFFFF_FFFF, 1, 0, 0);
    go(OP_BRANCH, 2, 32'h10, 32'h40, 5, 5, 0, 0);
    go(OP_BRANCH, 1, 32'h10, 32'h40, 5, 5, 0, 0);
    go(OP_JAL, 0, 4, 32'hFFFF_FFFC, 0, 0, 0, 0);
    go(OP_JAL, 0, 2, 32'h200, 0, 0, 0, 0);
    go(OP_JAL, 0, 1, 32'h200, 0, 0, 0, 0);
    go(OP_JALR, 1, 0, 32'h80, 32'h100, 0, 0, 0);
    go(7'h33, 0, 0, 32'h80, 1, 2, 0, 0);
    go(OP_BRANCH, 7, 32'h8, 32'h80, 3, 3, 5, 0);
    abort(OP_BRANCH, 0, 32'h8, 32'h80, 3, 3, 0);
    issue(OP_JAL, 0, 32'h40, 32'h500, 0, 0);
    @(posedge clk) #1;
    reset_n = 0;
    @(negedge clk) #1;
    reset_n = 1;
    @(posedge clk) #1;
    go(OP_JAL, 0, 32'h40, 32'h500, 0, 0, 0, 0);
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      o = sel < 3 ? OP_JAL : sel < 5 ? OP_JALR : sel < 9 ? OP_BRANCH : 7'($urandom);
      f = 3'($urandom);
      if (o == OP_JALR && $urandom_range(0, 3) != 0) f = 0;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) abort(o, f, 32'($urandom_range(0, 255)) - 32'd128, $urandom & ~32'd3, a,
                                           $urandom_range(0, 3) == 0 ? a : $urandom, $urandom_range(0, 2));
      else go(o, f, 32'($urandom_range(0, 255)) - 32'd128, $urandom & ~32'd3, a,
              $urandom_range(0, 3) == 0 ? a : $urandom, $urandom_range(0, 2), 1);
    end
    repeat (2) @(posedge clk) #1;
    done = 1;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got %0d/%0d checks", n_pass, n_tot);
    $fatal(1);
  end
endmodule
